// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin owner of one shared delay counter.
// Latches the winner's delay, runs the counter, pulses done to the winner.
module delay_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] delay,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_reset,
  output logic [WIDTH-1:0]       cnt_num,
  input  logic                   cnt_counted
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] num_q, num_d;

  logic [WIDTH-1:0] dly [N_REQ];
  logic             found;
  logic [IW-1:0]    pick;
  logic [IW:0]      idx;
  logic [IW-1:0]    sel_inc;
  logic [N_REQ-1:0] sel_oh;

  // Split the flat delay bus into one word per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_dly
    assign dly[g] = delay[g*WIDTH +: WIDTH];
  end

  // Pointer past the current owner, wrapping at N_REQ.
  assign sel_inc = (sel_q == IW'(N_REQ-1)) ? '0 : sel_q + 1'b1;

  assign sel_oh = N_REQ'(1) << sel_q;

  // Round-robin search: first raised req at or above ptr, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(j);
      if (idx >= (IW+1)'(N_REQ)) begin
        idx = idx - (IW+1)'(N_REQ);
      end
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  // State, rr pointer, owner and latched delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      num_q   <= num_d;
    end
  end

  // Next state: abort outranks counted; ptr moves past sel on exit.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    num_d   = num_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          num_d   = dly[pick];
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = (num_q == '0) ? DONE : RUN;
      end
      RUN: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_inc;
        end else if (cnt_counted) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = sel_inc;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    grant     = '0;
    done      = '0;
    busy      = 1'b1;
    cnt_reset = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      LOAD: begin
        grant = sel_oh;
      end
      RUN: begin
        grant     = sel_oh;
        cnt_reset = 1'b0;
      end
      DONE: begin
        grant = sel_oh;
        done  = sel_oh;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign cnt_num = num_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: random requesters against a transaction-level
// schedule model, with a scoreboard monitor and a reset scenario.
module tb_delay_arbiter;

  localparam int N = 4;
  localparam int W = 24;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] delay = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic           cnt_reset;
  logic [W-1:0]   cnt_num;
  logic           cnt_counted;

  logic [W-1:0]   ccount = '0;
  logic           ccounted = 1'b0;

  int  edge_n = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;

  typedef struct {
    int id;
    int rise;
    int fall;
    int d;
    int gedge;
    int endedge;
    bit ab;
    int lowcnt;
  } plan_t;

  plan_t plan[$];
  plan_t expq[$];

  delay_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .delay(delay),
    .grant(grant),
    .done(done),
    .busy(busy),
    .cnt_reset(cnt_reset),
    .cnt_num(cnt_num),
    .cnt_counted(cnt_counted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Shared counter: counted rises once num edges pass with reset low.
  always @(posedge clk) begin
    if (cnt_reset) begin
      ccount   <= '0;
      ccounted <= 1'b0;
    end else begin
      ccount <= ccount + 1'b1;
      if (ccount + 1'b1 >= cnt_num) ccounted <= 1'b1;
    end
  end
  assign cnt_counted = ccounted;

  task automatic chk(input string name, input int act, input int rq);
    checks++;
    if (act !== rq) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, rq);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Service schedule from the arbitration rules, in edge numbers.
  task automatic build_plan(input int t0, input int per_req);
    int arr[N];
    int left[N];
    int ptr;
    int tfree;
    int tmin;
    int t;
    int w;
    int i;
    int k;
    plan_t p;
    ptr = 0;
    tfree = t0;
    for (int r = 0; r < N; r++) begin
      arr[r]  = t0 + $urandom_range(0, 8);
      left[r] = per_req;
    end
    while (1) begin
      tmin = -1;
      for (int r = 0; r < N; r++)
        if (left[r] > 0 && (tmin < 0 || arr[r] < tmin)) tmin = arr[r];
      if (tmin < 0) break;
      t = (tfree > tmin) ? tfree : tmin;
      w = -1;
      for (int j = 0; j < N; j++) begin
        i = (ptr + j) % N;
        if (w < 0 && left[i] > 0 && arr[i] <= t) w = i;
      end
      p.id    = w;
      p.rise  = arr[w];
      p.gedge = t;
      p.d  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      p.ab = (p.d > 0) && ($urandom_range(0, 3) == 0);
      if (p.ab) begin
        if ($urandom_range(0, 2) == 0) k = p.d + 1;
        else k = $urandom_range(1, p.d + 1);
        p.endedge = t + 1 + k;
        p.fall    = p.endedge;
        p.lowcnt  = k;
        tfree     = p.endedge + 1;
      end else begin
        p.endedge = (p.d == 0) ? t + 1 : t + 2 + p.d;
        p.fall    = p.endedge + 2;
        p.lowcnt  = (p.d == 0) ? 0 : p.d + 1;
        tfree     = p.endedge + 2;
      end
      plan.push_back(p);
      ptr = (w + 1) % N;
      left[w]--;
      arr[w] = p.fall + 1 + $urandom_range(0, 15);
    end
  endtask

  int    cur = -1;
  int    cur_i = 0;
  int    low = 0;
  plan_t cur_e;

  // Monitor: pops the scoreboard on grant start, done and abort.
  always @(negedge clk) begin
    int w;
    int ei;
    if (mon_en && edge_n == 3) begin
      chk("reset_grant", grant, 0);
      chk("reset_done", done, 0);
      chk("reset_busy", busy, 0);
      chk("reset_cnt_reset", cnt_reset, 1);
      chk("reset_cnt_num", cnt_num, 0);
    end else if (mon_en && edge_n > 3) begin
      chk("busy", busy, int'(grant != 0));
      if (grant == 0) chk("cnt_reset_idle", cnt_reset, 1);
      if (cur < 0) begin
        if (done != 0) chk("spurious_done", done, 0);
        if (grant != 0) begin
          chk("grant_onehot", int'($onehot(grant)), 1);
          w = 0;
          for (int r = 0; r < N; r++) if (grant[r]) w = r;
          ei = -1;
          for (int k = 0; k < expq.size(); k++)
            if (ei < 0 && expq[k].id == w) ei = k;
          if (ei < 0) begin
            chk("grant_without_request", w, -1);
          end else begin
            cur_e = expq[ei];
            cur_i = ei;
            cur   = w;
            low   = 0;
            chk("grant_edge", edge_n, cur_e.gedge);
            chk("grant_num", cnt_num, cur_e.d);
          end
        end
      end else begin
        if (cnt_reset == 1'b0) low++;
        if (done != 0) begin
          chk("done_onehot", done, 1 << cur);
          chk("done_grant", grant, 1 << cur);
          chk("end_by_done", 1, int'(!cur_e.ab));
          chk("done_edge", edge_n, cur_e.endedge);
          chk("run_cycles", low, cur_e.lowcnt);
          expq.delete(cur_i);
          cur = -1;
        end else if (grant == 0) begin
          chk("end_by_abort", 0, int'(!cur_e.ab));
          chk("abort_edge", edge_n, cur_e.endedge);
          chk("run_cycles", low, cur_e.lowcnt);
          expq.delete(cur_i);
          cur = -1;
        end else begin
          chk("grant_held", grant, 1 << cur);
          chk("num_held", cnt_num, cur_e.d);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int n;
    int got;
    logic [N-1:0]   rq;
    logic [N*W-1:0] dv;

    build_plan(4, 12);
    last = 0;
    foreach (plan[k]) if (plan[k].fall > last) last = plan[k].fall;
    mon_en = 1'b1;

    while (edge_n < last + 6) begin
      tick();
      n  = edge_n + 1;
      rq = '0;
      for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom());
      foreach (plan[k]) begin
        if (plan[k].rise <= n && n < plan[k].fall) begin
          rq[plan[k].id] = 1'b1;
          if (n <= plan[k].gedge) dv[plan[k].id*W +: W] = W'(plan[k].d);
          if (n == plan[k].rise) expq.push_back(plan[k]);
        end
      end
      reset = (n <= 3);
      req   = rq;
      delay = dv;
    end
    chk("scoreboard_drained", expq.size(), 0);
    chk("no_open_grant", cur, -1);

    mon_en = 1'b0;
    req    = '0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    req   = 4'b0001;
    delay = '0;
    delay[0 +: W] = W'(50);
    tick();
    chk("rst_grant0", grant, 1);
    repeat (10) tick();
    chk("rst_running", cnt_reset, 0);
    chk("rst_busy_run", busy, 1);
    reset = 1'b1;
    tick();
    chk("midrun_grant", grant, 0);
    chk("midrun_done", done, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_cnt_reset", cnt_reset, 1);
    chk("midrun_cnt_num", cnt_num, 0);
    reset = 1'b0;
    req   = 4'b1001;
    delay[0 +: W]   = W'(2);
    delay[3*W +: W] = W'(2);
    tick();
    chk("ptr0_after_reset", grant, 1);
    got = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      tick();
      if (done != 0) got = 1;
    end
    chk("rst_done_req0", done, 1);
    req = 4'b1000;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      if (grant != 0) got = 1;
    end
    chk("next_grant_req3", grant, 8);
    got = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      tick();
      if (done != 0) got = 1;
    end
    chk("done_req3", done, 8);
    req = '0;
    tick();
    tick();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_arbiter.md
Name: delay_arbiter

Overview:
- Shares one 24-bit delay counter (`counter`: clk, reset, num, counted) among N_REQ requesters.
- Each requester asks for a programmed delay. The arbiter picks one requester round-robin, loads the counter, runs it, and returns a one-cycle done pulse to the winner.
- Sits between the timing clients (sequencers, debounce/step timers) and the single shared counter instance. It drives the counter's reset and num inputs and watches its counted output.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 24, delay/count width; must match the counter's num width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request level; held high until done, or dropped to abort.
- delay  input  N_REQ*WIDTH  requested delay; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot; the requester currently owning the counter.
- done  output  N_REQ  one-hot, one-cycle pulse when the granted delay has elapsed.
- busy  output  1  high whenever state is not IDLE.
- cnt_reset  output  1  drives counter reset; high holds the counter cleared.
- cnt_num  output  WIDTH  drives counter num; the latched delay of the winner.
- cnt_counted  input  1  counter counted flag.

Behaviour:
- Counter contract: counted goes high once num cycles have elapsed with reset low. It stays high until reset is reasserted.
- Reset (synchronous):
  - state=IDLE, rr pointer=0, sel=0, latched num=0.
  - grant=0, done=0, busy=0, cnt_reset=1, cnt_num=0.
  - Takes effect on the next edge, including mid-RUN; no done is issued for the interrupted request.
- All outputs are decoded from registered state, sel and latched num. There is no combinational path from req or cnt_counted to any output.
- IDLE:
  - Outputs: cnt_reset=1, grant=0, done=0.
  - If any req bit is high, choose the first set bit searching upward from ptr, wrapping mod N_REQ.
  - Register sel, latch num=delay[sel], go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD (1 cycle):
  - Outputs: cnt_reset=1, cnt_num=latched num, grant=onehot(sel).
  - cnt_counted is ignored in this state.
  - Next state is DONE if latched num==0, else RUN.
- RUN:
  - Outputs: cnt_reset=0, grant held, cnt_num held.
  - If req[sel]==0: abort. Go to IDLE, set ptr=(sel+1) mod N_REQ, no done. Abort takes priority over counted in the same cycle.
  - Else if cnt_counted==1: go to DONE.
- DONE (1 cycle):
  - Outputs: done=onehot(sel), grant held, cnt_reset=1.
  - Set ptr=(sel+1) mod N_REQ, go to IDLE.
- Changes to delay after the IDLE latch cycle have no effect on the running request.
- Latency:
  - req high in IDLE at edge t gives grant at t+1 (LOAD) and cnt_reset low at t+2.
  - done pulses one cycle after cnt_counted is first sampled high in RUN.
  - Zero delay: done at t+2.
- A requester must drop req in the cycle after done. If req is still high in the following IDLE, it is a new request at lowest priority.
- Minimum gap between successive grants is 1 IDLE cycle.
- Requests from non-granted requesters remain pending; they are never lost or acknowledged early.

Test Plan:
- Single request: req=0001, delay0=5, real counter attached.
  - Required: grant=0001 the cycle after req.
  - Required: cnt_reset low 5 cycles before counted.
  - Required: done=0001 for exactly 1 cycle, then busy=0.
- Round-robin: req=1111 held, all delays 3, each requester drops req after its done.
  - Required: grant order 0,1,2,3.
  - Required: re-raising req0 during 3's run serves 0 next.
- Zero delay: req=0100, delay2=0.
  - Required: done=0100 two cycles after req.
  - Required: cnt_reset stays high throughout.
- Abort: req=0010, delay1=100, drop req1 after 10 RUN cycles.
  - Required: returns to IDLE next cycle, cnt_reset=1.
  - Required: no done; ptr=2, so with req=0011 next, requester 0 wins only if 2 and 3 are idle.
- Reset mid-RUN: assert reset during a delay=50 run.
  - Required: one edge later grant=0, done=0, busy=0, cnt_reset=1.
  - Required: after deasserting reset with req=1001, requester 0 wins (ptr=0).
- Simultaneous abort and counted: drop req[sel] in the same cycle cnt_counted rises.
  - Required: no done pulse; next state IDLE.
